// File: rtl/wash_phase_timer.sv
// Phase timer for the washing machine: infers wash/spin from motor/drain and raises the matching timeout.
// Optional macro WASH_TIMER_PAUSE_EN adds a door_close input that freezes counting while the door is open.
module wash_phase_timer #(
    parameter int PRESCALE   = 10,
    parameter int WASH_TICKS = 6,
    parameter int SPIN_TICKS = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             motor_on,
    input  logic             drain_value_on,
`ifdef WASH_TIMER_PAUSE_EN
    input  logic             door_close,
`endif
    output logic             cycle_timeout,
    output logic             spin_timeout,
    output logic [CNT_W-1:0] remaining,
    output logic [1:0]       phase
);

    localparam int PW = $clog2(PRESCALE + 1);
    localparam logic [PW-1:0]    PRE_MAX   = PW'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] WASH_LOAD = CNT_W'(WASH_TICKS);
    localparam logic [CNT_W-1:0] SPIN_LOAD = CNT_W'(SPIN_TICKS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WASH,
        S_WASH_DONE,
        S_SPIN,
        S_SPIN_DONE
    } state_t;

    state_t          state_reg;
    logic [PW-1:0]   prescale_reg;
    logic            wash_req;
    logic            spin_req;
    logic            run_en;
    logic            in_wash;
    logic            in_spin;

    assign wash_req = motor_on & ~drain_value_on;
    assign spin_req = motor_on &  drain_value_on;
    assign in_wash  = (state_reg == S_WASH) || (state_reg == S_WASH_DONE);
    assign in_spin  = (state_reg == S_SPIN) || (state_reg == S_SPIN_DONE);

`ifdef WASH_TIMER_PAUSE_EN
    assign run_en = door_close;
`else
    assign run_en = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            prescale_reg  <= '0;
            remaining     <= '0;
            cycle_timeout <= 1'b0;
            spin_timeout  <= 1'b0;
            phase         <= 2'b00;
        end else if (!motor_on) begin
            // Motor off aborts any phase without a timeout.
            state_reg     <= S_IDLE;
            prescale_reg  <= '0;
            remaining     <= '0;
            cycle_timeout <= 1'b0;
            spin_timeout  <= 1'b0;
            phase         <= 2'b00;
        end else if (wash_req && !in_wash) begin
            state_reg     <= S_WASH;
            prescale_reg  <= '0;
            remaining     <= WASH_LOAD;
            cycle_timeout <= 1'b0;
            spin_timeout  <= 1'b0;
            phase         <= 2'b01;
        end else if (spin_req && !in_spin) begin
            state_reg     <= S_SPIN;
            prescale_reg  <= '0;
            remaining     <= SPIN_LOAD;
            cycle_timeout <= 1'b0;
            spin_timeout  <= 1'b0;
            phase         <= 2'b10;
        end else if ((state_reg == S_WASH || state_reg == S_SPIN) && run_en) begin
            if (prescale_reg == PRE_MAX) begin
                prescale_reg <= '0;
                if (remaining <= CNT_W'(1)) begin
                    // Last tick: expire on this edge so latency is exactly TICKS*PRESCALE.
                    remaining <= '0;
                    phase     <= 2'b11;
                    if (state_reg == S_WASH) begin
                        state_reg     <= S_WASH_DONE;
                        cycle_timeout <= 1'b1;
                    end else begin
                        state_reg    <= S_SPIN_DONE;
                        spin_timeout <= 1'b1;
                    end
                end else begin
                    remaining <= remaining - CNT_W'(1);
                end
            end else begin
                prescale_reg <= prescale_reg + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_wash_phase_timer.sv
// Directed bench for wash_phase_timer with an elapsed-cycle reference model checked every cycle.
module tb_wash_phase_timer;

    localparam int P  = 2;
    localparam int WT = 3;
    localparam int ST = 2;
    localparam int CW = 8;

    localparam int K_IDLE  = 0;
    localparam int K_WASH  = 1;
    localparam int K_SPIN  = 2;
    localparam int K_WDONE = 3;
    localparam int K_SDONE = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          motor_on = 1'b0;
    logic          drain_value_on = 1'b0;
    logic          door_close = 1'b1;
    logic          cycle_timeout;
    logic          spin_timeout;
    logic [CW-1:0] remaining;
    logic [1:0]    phase;

    int n_checks = 0;
    int n_fail   = 0;

    int m_kind  = K_IDLE;
    int m_el    = 0;
    bit started = 1'b0;

    wash_phase_timer #(
        .PRESCALE(P), .WASH_TICKS(WT), .SPIN_TICKS(ST), .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .motor_on(motor_on),
        .drain_value_on(drain_value_on),
`ifdef WASH_TIMER_PAUSE_EN
        .door_close(door_close),
`endif
        .cycle_timeout(cycle_timeout),
        .spin_timeout(spin_timeout),
        .remaining(remaining),
        .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int total_cycles(input int k);
        return (k == K_WASH) ? WT * P : ST * P;
    endfunction

    function automatic int exp_rem();
        if (m_kind == K_WASH) return WT - m_el / P;
        if (m_kind == K_SPIN) return ST - m_el / P;
        return 0;
    endfunction

    function automatic int exp_phase();
        if (m_kind == K_WASH) return 1;
        if (m_kind == K_SPIN) return 2;
        if (m_kind == K_IDLE) return 0;
        return 3;
    endfunction

    // Reference: count cycles spent in the current phase; expiry when the count reaches TICKS*PRESCALE.
    always @(posedge clk) begin
        started <= 1'b1;
        if (reset) begin
            m_kind <= K_IDLE;
            m_el   <= 0;
        end else begin
            case (m_kind)
                K_IDLE: begin
                    if (motor_on) begin
                        m_kind <= drain_value_on ? K_SPIN : K_WASH;
                        m_el   <= 0;
                    end
                end
                K_WASH, K_SPIN: begin
                    if (!motor_on) begin
                        m_kind <= K_IDLE;
                        m_el   <= 0;
                    end else if ((drain_value_on ? K_SPIN : K_WASH) != m_kind) begin
                        m_kind <= drain_value_on ? K_SPIN : K_WASH;
                        m_el   <= 0;
                    end else if (door_close) begin
                        m_el <= m_el + 1;
                        if (m_el + 1 == total_cycles(m_kind))
                            m_kind <= (m_kind == K_WASH) ? K_WDONE : K_SDONE;
                    end
                end
                default: begin
                    if (!motor_on) begin
                        m_kind <= K_IDLE;
                        m_el   <= 0;
                    end else if (m_kind == K_WDONE && drain_value_on) begin
                        m_kind <= K_SPIN;
                        m_el   <= 0;
                    end else if (m_kind == K_SDONE && !drain_value_on) begin
                        m_kind <= K_WASH;
                        m_el   <= 0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("model_remaining", int'(remaining), exp_rem());
            check("model_phase", int'(phase), exp_phase());
            check("model_cycle_timeout", int'(cycle_timeout), (m_kind == K_WDONE) ? 1 : 0);
            check("model_spin_timeout", int'(spin_timeout), (m_kind == K_SDONE) ? 1 : 0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    int rem_lit[6] = '{3, 3, 2, 2, 1, 1};

    initial begin
        step(2);
        check("reset_remaining", int'(remaining), 0);
        check("reset_phase", int'(phase), 0);
        check("reset_cycle_timeout", int'(cycle_timeout), 0);
        check("reset_spin_timeout", int'(spin_timeout), 0);
        reset = 1'b0;
        step(1);

        // 1: full wash
        motor_on = 1'b1;
        drain_value_on = 1'b0;
        step(1);
        check("s1_phase_wash", int'(phase), 1);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("s1_remaining_%0d", i), int'(remaining), rem_lit[i]);
            step(1);
        end
        check("s1_cycle_timeout", int'(cycle_timeout), 1);
        check("s1_phase_done", int'(phase), 3);
        step(3);
        check("s1_cycle_timeout_hold", int'(cycle_timeout), 1);

        // 2: wash done -> spin -> idle
        drain_value_on = 1'b1;
        step(1);
        check("s2_cycle_timeout_clr", int'(cycle_timeout), 0);
        check("s2_remaining_load", int'(remaining), 2);
        check("s2_phase_spin", int'(phase), 2);
        step(3);
        check("s2_spin_timeout_early", int'(spin_timeout), 0);
        step(1);
        check("s2_spin_timeout", int'(spin_timeout), 1);
        motor_on = 1'b0;
        step(1);
        check("s2_idle_phase", int'(phase), 0);
        check("s2_idle_spin_timeout", int'(spin_timeout), 0);
        check("s2_idle_remaining", int'(remaining), 0);

        // 3: abort at remaining=1, then re-enter
        motor_on = 1'b1;
        drain_value_on = 1'b0;
        step(5);
        check("s3_remaining_1", int'(remaining), 1);
        motor_on = 1'b0;
        step(1);
        check("s3_abort_phase", int'(phase), 0);
        step(3);
        check("s3_no_timeout", int'(cycle_timeout), 0);
        motor_on = 1'b1;
        step(1);
        check("s3_reload", int'(remaining), 3);

        // 4: reset on the expiry edge
        step(5);
        check("s4_remaining_1", int'(remaining), 1);
        reset = 1'b1;
        step(1);
        check("s4_reset_phase", int'(phase), 0);
        check("s4_reset_cycle_timeout", int'(cycle_timeout), 0);
        check("s4_reset_remaining", int'(remaining), 0);
        reset = 1'b0;
        motor_on = 1'b0;
        step(2);
        check("s4_no_timeout", int'(cycle_timeout), 0);

        // 5: wash -> spin switch mid-tick
        motor_on = 1'b1;
        drain_value_on = 1'b0;
        step(4);
        check("s5_remaining_2", int'(remaining), 2);
        drain_value_on = 1'b1;
        step(1);
        check("s5_phase_spin", int'(phase), 2);
        check("s5_remaining_load", int'(remaining), 2);
        step(1);
        check("s5_prescaler_restart", int'(remaining), 2);
        step(2);
        check("s5_remaining_1", int'(remaining), 1);
        check("s5_spin_early", int'(spin_timeout), 0);
        step(1);
        check("s5_spin_timeout", int'(spin_timeout), 1);
        check("s5_no_cycle_timeout", int'(cycle_timeout), 0);
        motor_on = 1'b0;
        step(1);

`ifdef WASH_TIMER_PAUSE_EN
        // 6: door open for 5 cycles at remaining=2
        drain_value_on = 1'b0;
        motor_on = 1'b1;
        step(3);
        check("s6_remaining_2", int'(remaining), 2);
        door_close = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check($sformatf("s6_frozen_%0d", i), int'(remaining), 2);
        end
        door_close = 1'b1;
        step(3);
        check("s6_timeout_delayed", int'(cycle_timeout), 0);
        step(1);
        check("s6_timeout", int'(cycle_timeout), 1);
        motor_on = 1'b0;
        step(1);
`endif

        step(1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
